// File: rtl/ct_mmu_jtlb_tag_arb.sv
`default_nettype none
// ============================================================================
// Module   : ct_mmu_jtlb_tag_arb
// Purpose  : Arbiter/sequencer for the single-port JTLB tag array
//            (256 entries x 196 bits = four 48-bit ways + 4-bit FIFO field).
//            Shares the array between PTW refill writes, JTLB lookup reads
//            and a full-array invalidate sweep (TLBI-all).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   forever_cpuclk        clock
//   cpurst                synchronous active-high reset
//   wr_req/idx/way/tag/fifo, wr_gnt      refill write channel
//   rd_req/idx, rd_gnt                   lookup read channel
//   rd_data_vld, rd_data                 read return (one cycle after rd_gnt)
//   jtlb_tag_dout                        array read data (passed to rd_data)
//   sweep_req, sweep_busy, sweep_done    invalidate-all sweep control
//   jtlb_tag_cen/idx/wen/din             array control
// Configuration
//   CT_MMU_JTLB_SWEEP_YIELD_EN : when defined, lookup reads may take sweep
//   slots (at most three consecutive yields before the sweep takes one).
// ============================================================================
module ct_mmu_jtlb_tag_arb (
    input  logic         forever_cpuclk,
    input  logic         cpurst,
    // refill write
    input  logic         wr_req,
    input  logic [7:0]   wr_idx,
    input  logic [3:0]   wr_way,
    input  logic [47:0]  wr_tag,
    input  logic [3:0]   wr_fifo,
    output logic         wr_gnt,
    // lookup read
    input  logic         rd_req,
    input  logic [7:0]   rd_idx,
    output logic         rd_gnt,
    output logic         rd_data_vld,
    output logic [195:0] rd_data,
    // invalidate sweep
    input  logic         sweep_req,
    output logic         sweep_busy,
    output logic         sweep_done,
    // tag array
    input  logic [195:0] jtlb_tag_dout,
    output logic         jtlb_tag_cen,
    output logic [7:0]   jtlb_tag_idx,
    output logic [4:0]   jtlb_tag_wen,
    output logic [195:0] jtlb_tag_din
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  sweep_cnt_q;
    logic [7:0]  sweep_cnt_d;
    logic        rd_vld_q;
    logic        yield_take;

`ifdef CT_MMU_JTLB_SWEEP_YIELD_EN
    logic [1:0]  yield_cnt_q;
    logic [1:0]  yield_cnt_d;

    // A pending read steals the sweep slot unless three slots in a row
    // have already been yielded; that bounds the sweep to 4 slots/index.
    assign yield_take = rd_req && (yield_cnt_q != 2'd3);
`else
    assign yield_take = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q     <= ST_IDLE;
            sweep_cnt_q <= 8'd0;
            rd_vld_q    <= 1'b0;
`ifdef CT_MMU_JTLB_SWEEP_YIELD_EN
            yield_cnt_q <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            rd_vld_q    <= rd_gnt;
`ifdef CT_MMU_JTLB_SWEEP_YIELD_EN
            yield_cnt_q <= yield_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next state, grants and array drive.
    // Everything is held quiet while cpurst is high so that a reset that
    // lands mid-sweep does not clear the index it interrupts.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sweep_cnt_d  = sweep_cnt_q;
`ifdef CT_MMU_JTLB_SWEEP_YIELD_EN
        yield_cnt_d  = yield_cnt_q;
`endif
        wr_gnt       = 1'b0;
        rd_gnt       = 1'b0;
        jtlb_tag_cen = 1'b0;
        jtlb_tag_idx = 8'd0;
        jtlb_tag_wen = 5'd0;
        jtlb_tag_din = 196'd0;

        if (!cpurst) begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_req) begin
                        // Tag is replicated to every way; wen picks which
                        // ways actually take it. FIFO field always written.
                        wr_gnt       = 1'b1;
                        jtlb_tag_cen = 1'b1;
                        jtlb_tag_idx = wr_idx;
                        jtlb_tag_wen = {1'b1, wr_way};
                        jtlb_tag_din = {wr_fifo, {4{wr_tag}}};
                    end else if (rd_req) begin
                        rd_gnt       = 1'b1;
                        jtlb_tag_cen = 1'b1;
                        jtlb_tag_idx = rd_idx;
                    end else if (sweep_req) begin
                        state_d     = ST_SWEEP;
                        sweep_cnt_d = 8'd0;
`ifdef CT_MMU_JTLB_SWEEP_YIELD_EN
                        yield_cnt_d = 2'd0;
`endif
                    end
                end

                ST_SWEEP: begin
                    if (yield_take) begin
                        rd_gnt       = 1'b1;
                        jtlb_tag_cen = 1'b1;
                        jtlb_tag_idx = rd_idx;
`ifdef CT_MMU_JTLB_SWEEP_YIELD_EN
                        yield_cnt_d  = yield_cnt_q + 2'd1;
`endif
                    end else begin
                        jtlb_tag_cen = 1'b1;
                        jtlb_tag_idx = sweep_cnt_q;
                        jtlb_tag_wen = 5'b11111;
`ifdef CT_MMU_JTLB_SWEEP_YIELD_EN
                        yield_cnt_d  = 2'd0;
`endif
                        // Last index ends the sweep; the counter is left
                        // at 255 rather than wrapping into a second pass.
                        if (sweep_cnt_q == 8'hFF) begin
                            state_d = ST_DONE;
                        end else begin
                            sweep_cnt_d = sweep_cnt_q + 8'd1;
                        end
                    end
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status and read return
    // ------------------------------------------------------------------
    assign sweep_busy  = !cpurst && ((state_q == ST_SWEEP) || (state_q == ST_DONE));
    assign sweep_done  = !cpurst && (state_q == ST_DONE);
    assign rd_data_vld = rd_vld_q && !cpurst;
    assign rd_data     = jtlb_tag_dout;

    // ------------------------------------------------------------------
    // Structural properties
    // ------------------------------------------------------------------
    a_gnt_excl: assert property (@(posedge forever_cpuclk) !(wr_gnt && rd_gnt));
    a_wen_cen:  assert property (@(posedge forever_cpuclk)
                                 (jtlb_tag_wen != 5'd0) |-> jtlb_tag_cen);

endmodule
`default_nettype wire

// File: tb/tb_ct_mmu_jtlb_tag_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_mmu_jtlb_tag_arb
// Purpose  : Self-checking bench for ct_mmu_jtlb_tag_arb with a behavioural
//            tag array, a reference copy of its contents and a read-data
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ct_mmu_jtlb_tag_arb;

`ifdef CT_MMU_JTLB_SWEEP_YIELD_EN
    localparam bit YIELD = 1'b1;
`else
    localparam bit YIELD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         cpurst;
    logic         wr_req;
    logic [7:0]   wr_idx;
    logic [3:0]   wr_way;
    logic [47:0]  wr_tag;
    logic [3:0]   wr_fifo;
    logic         wr_gnt;
    logic         rd_req;
    logic [7:0]   rd_idx;
    logic         rd_gnt;
    logic         rd_data_vld;
    logic [195:0] rd_data;
    logic         sweep_req;
    logic         sweep_busy;
    logic         sweep_done;
    logic [195:0] jtlb_tag_dout;
    logic         jtlb_tag_cen;
    logic [7:0]   jtlb_tag_idx;
    logic [4:0]   jtlb_tag_wen;
    logic [195:0] jtlb_tag_din;

    logic [195:0] mem     [256];
    logic [195:0] ref_mem [256];
    logic         preload;
    logic [195:0] sbq [$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ct_mmu_jtlb_tag_arb u_dut (
        .forever_cpuclk (clk),
        .cpurst         (cpurst),
        .wr_req         (wr_req),
        .wr_idx         (wr_idx),
        .wr_way         (wr_way),
        .wr_tag         (wr_tag),
        .wr_fifo        (wr_fifo),
        .wr_gnt         (wr_gnt),
        .rd_req         (rd_req),
        .rd_idx         (rd_idx),
        .rd_gnt         (rd_gnt),
        .rd_data_vld    (rd_data_vld),
        .rd_data        (rd_data),
        .sweep_req      (sweep_req),
        .sweep_busy     (sweep_busy),
        .sweep_done     (sweep_done),
        .jtlb_tag_dout  (jtlb_tag_dout),
        .jtlb_tag_cen   (jtlb_tag_cen),
        .jtlb_tag_idx   (jtlb_tag_idx),
        .jtlb_tag_wen   (jtlb_tag_wen),
        .jtlb_tag_din   (jtlb_tag_din)
    );

    function automatic logic [195:0] pat(input int i);
        logic [47:0] t;
        logic [3:0]  f;
        t = {i[7:0], 40'hC0_FFEE_1234};
        f = i[3:0] ^ 4'h5;
        return {f, t ^ 48'h3, t ^ 48'h2, t ^ 48'h1, t};
    endfunction

    // Behavioural single-port array: registered read, per-field writes.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (jtlb_tag_cen) begin
            if (jtlb_tag_wen == 5'd0) begin
                jtlb_tag_dout <= mem[jtlb_tag_idx];
            end else begin
                for (int w = 0; w < 4; w++)
                    if (jtlb_tag_wen[w])
                        mem[jtlb_tag_idx][w*48 +: 48] <= jtlb_tag_din[w*48 +: 48];
                if (jtlb_tag_wen[4])
                    mem[jtlb_tag_idx][195:192] <= jtlb_tag_din[195:192];
            end
        end
    end

    task automatic check(input string tag, input logic [195:0] act, input logic [195:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard: every granted read pushed by the stimulus is compared here.
    always @(negedge clk) begin
        if (rd_data_vld) begin
            if (sbq.size() == 0) check("rd_vld_unexpected", 196'(rd_data_vld), 196'(0));
            else                 check("rd_data", rd_data, sbq.pop_front());
        end
    end

    task automatic ref_write(input logic [7:0] i, input logic [3:0] way,
                             input logic [47:0] tag, input logic [3:0] fifo);
        for (int w = 0; w < 4; w++)
            if (way[w]) ref_mem[i][w*48 +: 48] = tag;
        ref_mem[i][195:192] = fifo;
    endtask

    task automatic set_idle();
        wr_req = 1'b0; rd_req = 1'b0; sweep_req = 1'b0;
    endtask

    task automatic slot(input string tag, input bit wg, input bit rg, input bit c,
                        input logic [7:0] i, input logic [4:0] w,
                        input logic [195:0] d, input bit chk_din);
        check({tag, "_wr_gnt"}, 196'(wr_gnt), 196'(wg));
        check({tag, "_rd_gnt"}, 196'(rd_gnt), 196'(rg));
        check({tag, "_cen"},    196'(jtlb_tag_cen), 196'(c));
        check({tag, "_idx"},    196'(jtlb_tag_idx), 196'(i));
        check({tag, "_wen"},    196'(jtlb_tag_wen), 196'(w));
        if (chk_din) check({tag, "_din"}, jtlb_tag_din, d);
    endtask

    task automatic status(input string tag, input bit busy, input bit done);
        check({tag, "_busy"}, 196'(sweep_busy), 196'(busy));
        check({tag, "_done"}, 196'(sweep_done), 196'(done));
    endtask

    task automatic do_write(input logic [7:0] i, input logic [3:0] way,
                            input logic [47:0] tag, input logic [3:0] fifo, input bit also_rd);
        @(posedge clk); #1;
        set_idle();
        wr_req = 1'b1; wr_idx = i; wr_way = way; wr_tag = tag; wr_fifo = fifo;
        rd_req = also_rd; rd_idx = i;
        @(negedge clk);
        slot("wr", 1'b1, 1'b0, 1'b1, i, {1'b1, way}, {fifo, {4{tag}}}, 1'b1);
        ref_write(i, way, tag, fifo);
    endtask

    task automatic do_read(input logic [7:0] i, input bit push);
        @(posedge clk); #1;
        set_idle();
        rd_req = 1'b1; rd_idx = i;
        @(negedge clk);
        slot("rd", 1'b0, 1'b1, 1'b1, i, 5'd0, 196'd0, 1'b0);
        if (push) sbq.push_back(ref_mem[i]);
    endtask

    task automatic idle_cyc();
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        slot("idle", 1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 196'd0, 1'b1);
        status("idle", 1'b0, 1'b0);
    endtask

    // Sweep with optional held write/read traffic and optional reset abort.
    task automatic run_sweep(input bit hold_wr, input bit hold_rd, input int abort_at);
        int k  = 0;
        int yc = 0;
        bit er;
        @(posedge clk); #1;
        set_idle();
        sweep_req = 1'b1;
        @(negedge clk);
        slot("sw_acc", 1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 196'd0, 1'b1);
        status("sw_acc", 1'b0, 1'b0);
        while (k < 256) begin
            @(posedge clk); #1;
            sweep_req = 1'b0;
            wr_req = hold_wr; wr_idx = 8'h55; wr_way = 4'b0011;
            wr_tag = 48'h1111_2222_3333; wr_fifo = 4'h9;
            rd_req = hold_rd; rd_idx = 8'h33;
            if (k == abort_at) begin
                cpurst = 1'b1;
                @(negedge clk);
                slot("sw_rst", 1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 196'd0, 1'b1);
                status("sw_rst", 1'b0, 1'b0);
                @(posedge clk); #1;
                cpurst = 1'b0;
                set_idle();
                @(negedge clk);
                slot("sw_post", 1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 196'd0, 1'b1);
                status("sw_post", 1'b0, 1'b0);
                return;
            end
            er = YIELD && hold_rd && (yc != 3);
            @(negedge clk);
            status("sw_run", 1'b1, 1'b0);
            if (er) begin
                slot("sw_yield", 1'b0, 1'b1, 1'b1, 8'h33, 5'd0, 196'd0, 1'b0);
                sbq.push_back(ref_mem[8'h33]);
                yc++;
            end else begin
                slot("sw_slot", 1'b0, 1'b0, 1'b1, 8'(k), 5'h1F, 196'd0, 1'b1);
                ref_mem[k] = 196'd0;
                k++;
                yc = 0;
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        slot("sw_done", 1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 196'd0, 1'b1);
        status("sw_done", 1'b1, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        status("sw_idle", 1'b0, 1'b0);
        if (hold_wr) begin
            slot("sw_wr_after", 1'b1, 1'b0, 1'b1, 8'h55, 5'b10011,
                 {4'h9, {4{48'h1111_2222_3333}}}, 1'b1);
            ref_write(8'h55, 4'b0011, 48'h1111_2222_3333, 4'h9);
        end else if (hold_rd) begin
            slot("sw_rd_after", 1'b0, 1'b1, 1'b1, 8'h33, 5'd0, 196'd0, 1'b0);
            sbq.push_back(ref_mem[8'h33]);
        end else begin
            slot("sw_nop_after", 1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 196'd0, 1'b1);
        end
        @(posedge clk); #1;
        set_idle();
    endtask

    initial begin
        cpurst = 1'b1; preload = 1'b1;
        wr_req = 1'b0; wr_idx = 8'd0; wr_way = 4'd0; wr_tag = 48'd0; wr_fifo = 4'd0;
        rd_req = 1'b0; rd_idx = 8'd0; sweep_req = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

        // Reset: all outputs quiet even with every request raised.
        @(posedge clk); #1;
        wr_req = 1'b1; rd_req = 1'b1; sweep_req = 1'b1; wr_way = 4'b0001;
        @(negedge clk);
        slot("rst", 1'b0, 1'b0, 1'b0, 8'd0, 5'd0, 196'd0, 1'b1);
        status("rst", 1'b0, 1'b0);
        check("rst_vld", 196'(rd_data_vld), 196'(0));
        @(posedge clk); #1;
        cpurst = 1'b0; preload = 1'b0;
        set_idle();
        @(negedge clk);
        idle_cyc();

        // Refill then lookup of the same index.
        do_write(8'h12, 4'b0100, 48'hABCD_1234_5678, 4'b0011, 1'b0);
        do_read(8'h12, 1'b1);
        // Write beats read in the same cycle; read follows.
        do_write(8'h40, 4'b0001, 48'h0BAD_F00D_0001, 4'hE, 1'b1);
        do_read(8'h40, 1'b1);
        // FIFO-only write and non-one-hot way mask.
        do_write(8'h41, 4'b0000, 48'hFFFF_0000_FFFF, 4'hC, 1'b0);
        do_read(8'h41, 1'b1);
        do_write(8'h42, 4'b1011, 48'h1234_5678_9ABC, 4'h6, 1'b0);
        do_read(8'h42, 1'b1);
        do_read(8'h00, 1'b1);
        do_read(8'hFF, 1'b1);
        idle_cyc();

        // Reset in the cycle after a grant suppresses the data strobe.
        do_read(8'h12, 1'b0);
        @(posedge clk); #1;
        cpurst = 1'b1;
        set_idle();
        @(negedge clk);
        check("rst_after_gnt_vld", 196'(rd_data_vld), 196'(0));
        @(posedge clk); #1;
        cpurst = 1'b0;
        @(negedge clk);
        check("post_rst_vld", 196'(rd_data_vld), 196'(0));

        // Full sweep with a write held throughout.
        run_sweep(1'b1, 1'b0, -1);
        do_read(8'h00, 1'b1);
        do_read(8'h12, 1'b1);
        do_read(8'h55, 1'b1);
        do_read(8'hFF, 1'b1);

        // Sweep with a read held throughout (yields when enabled).
        do_write(8'h33, 4'b1111, 48'hCAFE_BABE_0033, 4'h3, 1'b0);
        run_sweep(1'b0, 1'b1, -1);
        do_read(8'h33, 1'b1);

        // Reset aborts a sweep at index 100.
        do_write(8'd50,  4'b1111, 48'h0000_0000_0050, 4'h1, 1'b0);
        do_write(8'd99,  4'b1111, 48'h0000_0000_0099, 4'h2, 1'b0);
        do_write(8'd100, 4'b1111, 48'h0000_0000_0100, 4'h3, 1'b0);
        do_write(8'd101, 4'b0101, 48'h0000_0000_0101, 4'h4, 1'b0);
        do_write(8'd200, 4'b1000, 48'h0000_0000_0200, 4'h5, 1'b0);
        run_sweep(1'b0, 1'b0, 100);
        do_read(8'd50,  1'b1);
        do_read(8'd99,  1'b1);
        do_read(8'd100, 1'b1);
        do_read(8'd101, 1'b1);
        do_read(8'd200, 1'b1);
        do_read(8'd0,   1'b1);

        idle_cyc();
        idle_cyc();
        check("sb_empty", 196'(sbq.size()), 196'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
